// File: rtl/uart_arb_pkg.sv
// Shared state encoding and default timing for the UART TX arbiter.
// Also provides a small constant helper used for counter sizing.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_START_TO = 16;
    localparam int DEF_FRAME_TO = 2048;
    localparam int DEF_GAP_CYC  = 2;

    function automatic int max3(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first set request at or above ptr,
// wrapping modulo N.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 any,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] j;

    // Walk offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        any = |req;
        idx = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                idx = j;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ clients,
// with launch/busy handshake tracking and a stall watchdog.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int START_TO = DEF_START_TO,
    parameter int FRAME_TO = DEF_FRAME_TO,
    parameter int GAP_CYC  = DEF_GAP_CYC
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_par_en,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          done,
    output logic                      err,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_par_en,
    input  logic                      tx_busy,
    output logic                      active,
    output logic [$clog2(N_REQ)-1:0]  grant_idx
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(max3(START_TO, FRAME_TO, GAP_CYC) + 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_TO - 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_TO - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(N_REQ - 1);

    arb_state_e          state, state_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_inc;
    logic [IW-1:0]       rr_ptr, rr_ptr_n, gidx_n;
    logic [DATA_W-1:0]   data_q, data_n;
    logic                par_q, par_n;
    logic                pick_any;
    logic [IW-1:0]       pick_idx;
    logic                cmpl, tmo;
    logic [DATA_W-1:0]   req_bytes [N_REQ];

    logic [N_REQ-1:0]    ready_n, done_n;
    logic                err_n, start_n, txp_n, active_n;
    logic [DATA_W-1:0]   txd_n;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    rr_picker #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            req_ready <= '0;
            done      <= '0;
            err       <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            tx_par_en <= 1'b0;
            active    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            rr_ptr    <= rr_ptr_n;
            grant_idx <= gidx_n;
            data_q    <= data_n;
            par_q     <= par_n;
            req_ready <= ready_n;
            done      <= done_n;
            err       <= err_n;
            tx_start  <= start_n;
            tx_data   <= txd_n;
            tx_par_en <= txp_n;
            active    <= active_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt_inc;
        rr_ptr_n = rr_ptr;
        gidx_n   = grant_idx;
        data_n   = data_q;
        par_n    = par_q;
        cmpl     = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (pick_any && !tx_busy) begin
                    state_n = LAUNCH;
                    gidx_n  = pick_idx;
                    data_n  = req_bytes[pick_idx];
                    par_n   = req_par_en[pick_idx];
                end
            end
            LAUNCH: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                    cnt_n   = '0;
                end else if (cnt >= START_LAST) begin
                    cmpl = 1'b1;
                    tmo  = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cmpl = 1'b1;
                end else if (cnt >= FRAME_LAST) begin
                    cmpl = 1'b1;
                    tmo  = 1'b1;
                end
            end
            GAP: begin
                if (cnt >= GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Completion always advances the pointer past the served client.
        if (cmpl) begin
            rr_ptr_n = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            cnt_n    = '0;
            state_n  = (GAP_CYC == 0) ? IDLE : GAP;
        end
    end

    always_comb begin
        ready_n  = '0;
        done_n   = '0;
        err_n    = 1'b0;
        start_n  = 1'b0;
        txd_n    = tx_data;
        txp_n    = tx_par_en;
        active_n = (state_n != IDLE);
        if (state_n == LAUNCH) begin
            start_n         = 1'b1;
            ready_n[gidx_n] = 1'b1;
            txd_n           = data_n;
            txp_n           = par_n;
        end
        if (cmpl) begin
            done_n[grant_idx] = 1'b1;
            err_n             = tmo;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter
// (START_TO=16, FRAME_TO=64, GAP_CYC=2).
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int GAP = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_par_en = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    done;
    logic            err;
    logic            tx_start;
    logic [DW-1:0]   tx_data;
    logic            tx_par_en;
    logic            tx_busy = 1'b0;
    logic            active;
    logic [1:0]      grant_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ(N), .DATA_W(DW), .START_TO(16), .FRAME_TO(64), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_par_en(req_par_en),
        .req_ready(req_ready), .done(done), .err(err),
        .tx_start(tx_start), .tx_data(tx_data), .tx_par_en(tx_par_en),
        .tx_busy(tx_busy), .active(active), .grant_idx(grant_idx)
    );

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (tx_start !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done === '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({req_ready, done, err, tx_start, tx_par_en, active} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {req_ready, done, err, tx_start, tx_par_en, active});
        end
        n_checks++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00", tx_data);
        end
        n_checks++;
        if (grant_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_grant: got %0d expected 0", grant_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({active, tx_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 00", {active, tx_start});
        end
    endtask

    task automatic test_single();
        int extra, early;
        req_data[0 +: 8] = 8'hA5;
        req_par_en = 4'b0001;
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if ({tx_start, tx_data, tx_par_en, req_ready, grant_idx} !== {1'b1, 8'hA5, 1'b1, 4'b0001, 2'd0}) begin
            n_fail++;
            $display("FAIL single_launch: got start=%b data=%h par=%b ready=%b g=%0d expected 1 a5 1 0001 0",
                     tx_start, tx_data, tx_par_en, req_ready, grant_idx);
        end
        req_valid = '0;
        extra = 0;
        early = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) tx_busy = 1'b1;
            if (c == 11) tx_busy = 1'b0;
            if (tx_start || req_ready != '0) extra++;
            if (c != 12 && (done != '0 || err)) early++;
            if (c == 12) begin
                n_checks++;
                if ({done, err, tx_data} !== {4'b0001, 1'b0, 8'hA5}) begin
                    n_fail++;
                    $display("FAIL single_done: got done=%b err=%b data=%h expected 0001 0 a5",
                             done, err, tx_data);
                end
            end
            if (c == 13) begin
                n_checks++;
                if (active !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_gap: got active=%b expected 1", active);
                end
            end
            if (c == 14) begin
                n_checks++;
                if (active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL single_idle: got active=%b expected 0", active);
                end
            end
        end
        n_checks++;
        if (extra != 0 || early != 0) begin
            n_fail++;
            $display("FAIL single_stray: got extra=%0d early=%0d expected 0 0", extra, early);
        end
    endtask

    task automatic test_fairness();
        int cyc, g, exp_cyc;
        logic [3:0] exp_oh;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req_par_en = 4'b1010;
        req_valid = 4'b1111;
        for (int f = 0; f < 6; f++) begin
            g = f % 4;
            exp_oh = 4'b0001 << g;
            exp_cyc = (f == 0) ? 1 : GAP + 1;
            wait_start(cyc);
            n_checks++;
            if (cyc != exp_cyc || grant_idx !== 2'(g) || req_ready !== exp_oh ||
                tx_data !== 8'(8'h10 + g) || tx_par_en !== req_par_en[g]) begin
                n_fail++;
                $display("FAIL fair_launch%0d: got cyc=%0d g=%0d ready=%b data=%h par=%b expected %0d %0d %b %h %b",
                         f, cyc, grant_idx, req_ready, tx_data, tx_par_en,
                         exp_cyc, g, exp_oh, 8'(8'h10 + g), req_par_en[g]);
            end
            tx_busy = 1'b1;
            repeat (3) @(negedge clk);
            tx_busy = 1'b0;
            wait_done(cyc);
            n_checks++;
            if (cyc != 1 || done !== exp_oh || err !== 1'b0) begin
                n_fail++;
                $display("FAIL fair_done%0d: got cyc=%0d done=%b err=%b expected 1 %b 0",
                         f, cyc, done, err, exp_oh);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_start_timeout();
        int cyc, early;
        repeat (3) @(negedge clk);
        req_data[16 +: 8] = 8'h22;
        req_data[24 +: 8] = 8'h33;
        req_par_en = '0;
        req_valid = 4'b1100;
        wait_start(cyc);
        n_checks++;
        if (cyc != 1 || grant_idx !== 2'd2 || tx_data !== 8'h22) begin
            n_fail++;
            $display("FAIL sto_launch: got cyc=%0d g=%0d data=%h expected 1 2 22",
                     cyc, grant_idx, tx_data);
        end
        req_valid = 4'b1000;
        early = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c < 17 && (done != '0 || err)) early++;
            if (c == 17) begin
                n_checks++;
                if ({err, done} !== {1'b1, 4'b0100} || early != 0) begin
                    n_fail++;
                    $display("FAIL sto_err: got err=%b done=%b early=%0d expected 1 0100 0",
                             err, done, early);
                end
            end
        end
        wait_start(cyc);
        n_checks++;
        if (cyc != 3 || grant_idx !== 2'd3 || tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL sto_next: got cyc=%0d g=%0d data=%h expected 3 3 33",
                     cyc, grant_idx, tx_data);
        end
        req_valid = '0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 17 || {err, done} !== {1'b1, 4'b1000}) begin
            n_fail++;
            $display("FAIL sto_err2: got cyc=%0d err=%b done=%b expected 17 1 1000",
                     cyc, err, done);
        end
    endtask

    task automatic test_frame_timeout();
        int cyc, early, stray;
        repeat (3) @(negedge clk);
        req_data[8 +: 8] = 8'h5A;
        req_par_en = 4'b0010;
        req_valid = 4'b0010;
        wait_start(cyc);
        n_checks++;
        if (cyc != 1 || grant_idx !== 2'd1 || tx_data !== 8'h5A || tx_par_en !== 1'b1) begin
            n_fail++;
            $display("FAIL fto_launch: got cyc=%0d g=%0d data=%h par=%b expected 1 1 5a 1",
                     cyc, grant_idx, tx_data, tx_par_en);
        end
        req_valid = '0;
        tx_busy = 1'b1;
        early = 0;
        for (int c = 1; c <= 66; c++) begin
            @(negedge clk);
            if (c < 66 && (done != '0 || err)) early++;
            if (c == 66) begin
                n_checks++;
                if ({err, done} !== {1'b1, 4'b0010} || early != 0) begin
                    n_fail++;
                    $display("FAIL fto_err: got err=%b done=%b early=%0d expected 1 0010 0",
                             err, done, early);
                end
            end
        end
        req_data[0 +: 8] = 8'h0F;
        req_valid = 4'b0001;
        stray = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (tx_start) stray++;
            if (c == 2) begin
                n_checks++;
                if (active !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fto_idle: got active=%b expected 0", active);
                end
            end
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL fto_hold: got %0d launches expected 0", stray);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b1 || grant_idx !== 2'd0 || tx_data !== 8'h0F) begin
            n_fail++;
            $display("FAIL fto_relaunch: got start=%b g=%0d data=%h expected 1 0 0f",
                     tx_start, grant_idx, tx_data);
        end
        req_valid = '0;
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 1 || {err, done} !== {1'b0, 4'b0001}) begin
            n_fail++;
            $display("FAIL fto_done: got cyc=%0d err=%b done=%b expected 1 0 0001",
                     cyc, err, done);
        end
    endtask

    task automatic test_busy_idle();
        int cyc, stray;
        tx_busy = 1'b1;
        req_data[16 +: 8] = 8'hC3;
        req_par_en = 4'b0100;
        req_valid = 4'b0100;
        stray = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (tx_start) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL busy_idle_hold: got %0d launches expected 0", stray);
        end
        tx_busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tx_start, grant_idx, tx_data, req_ready} !== {1'b1, 2'd2, 8'hC3, 4'b0100}) begin
            n_fail++;
            $display("FAIL busy_idle_launch: got start=%b g=%0d data=%h ready=%b expected 1 2 c3 0100",
                     tx_start, grant_idx, tx_data, req_ready);
        end
        req_valid = '0;
        tx_busy = 1'b1;
        repeat (2) @(negedge clk);
        tx_busy = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 1 || {err, done} !== {1'b0, 4'b0100}) begin
            n_fail++;
            $display("FAIL busy_idle_done: got cyc=%0d err=%b done=%b expected 1 0 0100",
                     cyc, err, done);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        repeat (3) @(negedge clk);
        req_data[24 +: 8] = 8'h77;
        req_par_en = 4'b1000;
        req_valid = 4'b1000;
        wait_start(cyc);
        n_checks++;
        if (cyc != 1 || grant_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL rst_mid_launch: got cyc=%0d g=%0d expected 1 3", cyc, grant_idx);
        end
        req_valid = '0;
        tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({req_ready, done, err, tx_start, tx_data, tx_par_en, active, grant_idx} !== 22'h0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got ready=%b done=%b err=%b start=%b data=%h par=%b act=%b g=%0d expected all 0",
                     req_ready, done, err, tx_start, tx_data, tx_par_en, active, grant_idx);
        end
        reset = 1'b1;
        tx_busy = 1'b0;
        req_data[0 +: 8] = 8'h01;
        req_valid = 4'b1001;
        @(negedge clk);
        n_checks++;
        if ({tx_start, grant_idx, tx_data, req_ready} !== {1'b1, 2'd0, 8'h01, 4'b0001}) begin
            n_fail++;
            $display("FAIL rst_mid_winner: got start=%b g=%0d data=%h ready=%b expected 1 0 01 0001",
                     tx_start, grant_idx, tx_data, req_ready);
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_start_timeout();
        test_frame_timeout();
        test_busy_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
